// File: rtl/cnn16_mem_pkg.sv
// Shared types and defaults for the CNN16 memory arbiter.
package cnn16_mem_pkg;

  localparam int DEF_ADDR_W  = 12;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_TIMEOUT = 255;
  localparam int CNT_W       = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Encoding matches the bit position in the picker's request vector.
  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

endpackage

// File: rtl/cnn16_mem_arbiter_if.sv
// Memory-side bus of the CNN16 arbiter: master = arbiter, slave = memory.
interface cnn16_mem_arbiter_if
  import cnn16_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/cnn16_rr_pick.sv
// Two-way combinational picker; round-robin on a tie, or fixed CPU priority
// when CNN16_ARB_CPU_PRIORITY_EN is defined.
module cnn16_rr_pick
  import cnn16_mem_pkg::*;
(
  input  logic [1:0] req,        // [0] = CPU, [1] = DMA
  input  owner_e     last_owner,
  output owner_e     owner,
  output logic       valid
);

  always_comb begin
    valid = |req;
    owner = OWN_CPU;
`ifdef CNN16_ARB_CPU_PRIORITY_EN
    if (!req[0] && req[1]) begin
      owner = OWN_DMA;
    end
`else
    case (req)
      2'b10: owner = OWN_DMA;
      2'b11: begin
        if (last_owner == OWN_CPU) begin
          owner = OWN_DMA;
        end else begin
          owner = OWN_CPU;
        end
      end
      default: owner = OWN_CPU;
    endcase
`endif
  end

endmodule

// File: rtl/cnn16_mem_arbiter.sv
// CPU/DMA arbiter for the single-port CNN16 memory with latched requests and
// a mem_ready watchdog. Define CNN16_ARB_CPU_PRIORITY_EN for fixed CPU priority.
module cnn16_mem_arbiter
  import cnn16_mem_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_done,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_done,
  output logic [DATA_W-1:0] rdata,
  output logic              timeout_err,
  cnn16_mem_arbiter_if.master mem
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  state_e            state_reg, state_next;
  owner_e            owner_reg, owner_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic              done_reg, done_next;
  logic              tout_reg, tout_next;

  owner_e pick_owner;
  logic   pick_valid;

  cnn16_rr_pick u_pick (
    .req        ({dma_req, cpu_req}),
    .last_owner (owner_reg),
    .owner      (pick_owner),
    .valid      (pick_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      owner_reg     <= OWN_DMA;
      cnt_reg       <= '0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      rdata_reg     <= '0;
      done_reg      <= 1'b0;
      tout_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      owner_reg     <= owner_next;
      cnt_reg       <= cnt_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      rdata_reg     <= rdata_next;
      done_reg      <= done_next;
      tout_reg      <= tout_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    owner_next     = owner_reg;
    cnt_next       = cnt_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    rdata_next     = rdata_reg;
    done_next      = 1'b0;
    tout_next      = 1'b0;
    cpu_gnt        = 1'b0;
    dma_gnt        = 1'b0;

    case (state_reg)
      IDLE: begin
        // The done cycle is never a grant cycle, so gnt/done cannot overlap.
        if (pick_valid && !done_reg && !rst) begin
          owner_next = pick_owner;
          cnt_next   = '0;
          state_next = BUSY;
          if (pick_owner == OWN_DMA) begin
            dma_gnt        = 1'b1;
            mem_we_next    = dma_we;
            mem_addr_next  = dma_addr;
            mem_wdata_next = dma_wdata;
          end else begin
            cpu_gnt        = 1'b1;
            mem_we_next    = cpu_we;
            mem_addr_next  = cpu_addr;
            mem_wdata_next = cpu_wdata;
          end
        end
      end
      BUSY: begin
        if (mem.mem_ready) begin
          if (!mem_we_reg) begin
            rdata_next = mem.mem_rdata;
          end
          done_next  = 1'b1;
          state_next = IDLE;
        end else if (cnt_reg == CNT_MAX) begin
          rdata_next = '0;
          done_next  = 1'b1;
          tout_next  = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign cpu_done      = done_reg && (owner_reg == OWN_CPU);
  assign dma_done      = done_reg && (owner_reg == OWN_DMA);
  assign timeout_err   = tout_reg;
  assign rdata         = rdata_reg;
  assign mem.mem_req   = (state_reg == BUSY);
  assign mem.mem_we    = mem_we_reg;
  assign mem.mem_addr  = mem_addr_reg;
  assign mem.mem_wdata = mem_wdata_reg;

endmodule

// File: doc/cnn16_mem_arbiter.md
Name: cnn16_mem_arbiter

Overview:
- Shares the single-port program/data memory between two requesters:
  - the CPU datapath/control unit (fetch, operand, store);
  - a DMA/loader port that preloads kernels and images and drains results.
- Sits between both requesters and the memory interface (address/to_memory/from_memory/mem_ready).
- Serialises accesses with a two-way round-robin grant, latches each request, and waits on mem_ready with a watchdog timeout.

Parameters:
ADDR_W, 12, memory address width
DATA_W, 16, memory data width
TIMEOUT, 255, max cycles in BUSY without mem_ready before abort (1..65535)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
cpu_req  in  1  CPU access request, held until cpu_gnt
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_gnt  out  1  one-cycle pulse: CPU request accepted and latched
cpu_done  out  1  one-cycle pulse: CPU access finished
dma_req  in  1  DMA access request, held until dma_gnt
dma_we  in  1  1=write, 0=read
dma_addr  in  ADDR_W  DMA address
dma_wdata  in  DATA_W  DMA write data
dma_gnt  out  1  one-cycle pulse: DMA request accepted
dma_done  out  1  one-cycle pulse: DMA access finished
rdata  out  DATA_W  read data, valid in the done cycle, held until the next done
mem_req  out  1  memory access strobe, held through BUSY
mem_we  out  1  latched write enable
mem_addr  out  ADDR_W  latched address
mem_wdata  out  DATA_W  latched write data
mem_rdata  in  DATA_W  memory read data, valid with mem_ready
mem_ready  in  1  memory completion, sampled only in BUSY
timeout_err  out  1  one-cycle pulse with done when the watchdog fires

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; all outputs 0; rdata=0; counter=0.
  - last_owner=DMA, so the CPU wins the first tie.
  - Any access in flight is abandoned with no done pulse.
- States: IDLE, BUSY.
- IDLE:
  - If any req=1, pick an owner:
    - only one requester active: that one;
    - both active: the requester that is not last_owner.
  - In the same cycle: pulse owner gnt, latch owner we/addr/wdata into mem_* registers, set last_owner, clear counter, go to BUSY.
  - No req: stay in IDLE with mem_req=0.
- BUSY:
  - mem_req=1; mem_we/addr/wdata hold the latched values; req inputs are ignored.
  - On mem_ready=1:
    - for a read, capture mem_rdata into rdata (writes leave rdata unchanged);
    - pulse owner done next cycle;
    - drop mem_req; go to IDLE.
  - Otherwise increment counter.
  - Counter reaches TIMEOUT-1 with no mem_ready:
    - drop mem_req; rdata=0;
    - pulse owner done and timeout_err together;
    - go to IDLE.
- Latency:
  - req sampled high in IDLE at edge N gives gnt in cycle N and mem_req from N+1.
  - mem_ready at N+1 gives done at N+2. Minimum three-cycle access.
- Back-to-back: a requester may hold req through its done cycle. It is re-arbitrated in the IDLE cycle that follows, so both requesters alternate under contention.
- Requester dropping req after gnt: the access still completes.
- mem_ready seen in IDLE: ignored.
- The done and gnt pulses of different requesters may coincide only across different cycles. They never overlap for the same requester.

Optional Feature:
- CNN16_ARB_CPU_PRIORITY_EN defined: fixed priority, CPU always wins a tie; last_owner is unused; DMA can starve.
- Undefined: round-robin as specified above.

Decomposition:
- Package cnn16_mem_pkg holds:
  - state enum {IDLE, BUSY};
  - owner encoding {OWN_CPU=0, OWN_DMA=1};
  - ADDR_W/DATA_W defaults;
  - default TIMEOUT constant.
- Sub-module cnn16_rr_pick: 2-way combinational picker (req[1:0], last_owner → owner, valid), including the priority macro variant.

Test Plan:
- Reset, then cpu_req=1, cpu_we=0, cpu_addr=0x010; memory returns 0xBEEF with mem_ready one cycle later -> cpu_gnt at cycle 0, mem_addr=0x010, cpu_done at cycle 2, rdata=0xBEEF.
- cpu_req and dma_req both held high for 4 accesses -> grants in order CPU, DMA, CPU, DMA; with CNN16_ARB_CPU_PRIORITY_EN -> CPU, CPU, CPU, CPU.
- DMA write to addr 0xFFF with data 0x1234, mem_ready delayed 5 cycles -> mem_req high 6 cycles, mem_we=1, signals stable throughout, dma_done once, rdata unchanged.
- TIMEOUT=8, mem_ready never asserted -> mem_req drops after 8 BUSY cycles; cpu_done and timeout_err pulse together; rdata=0.
- rst asserted mid-BUSY -> outputs 0 immediately (asynchronous); no done pulse; next CPU/DMA tie goes to CPU.
- cpu_req deasserted the cycle after cpu_gnt, and mem_ready pulsed while in IDLE -> access still completes with cpu_done; the IDLE mem_ready causes no state change.
